// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg
// Shared definitions for the CPU byte-bus target: MMIO address map,
// TMR_CTRL field positions and timer reset constants.
package cpu_bus_pkg;

    typedef logic [6:0] addr_t;

    // MMIO register addresses
    localparam addr_t ADDR_GPIO_OUT = 7'h70;
    localparam addr_t ADDR_GPIO_IN  = 7'h71;
    localparam addr_t ADDR_TMR_CNT  = 7'h72;
    localparam addr_t ADDR_TMR_CMP  = 7'h73;
    localparam addr_t ADDR_TMR_CTRL = 7'h74;
    localparam addr_t ADDR_STATUS   = 7'h75;

    // TMR_CTRL bit positions
    localparam int unsigned CTRL_EN        = 0;
    localparam int unsigned CTRL_IE        = 1;
    localparam int unsigned CTRL_PRESC_LSB = 4;
    localparam int unsigned CTRL_PRESC_MSB = 7;

    localparam logic [7:0] TMR_CMP_RST = 8'hFF;

    // TMR_CTRL write mask: bits [3:2] are held at 0.
    function automatic logic [7:0] ctrl_mask(input logic [7:0] d);
        return d & 8'hF3;
    endfunction

endpackage

// File: rtl/cpu_bus_target_bus_timer.sv
// bus_timer
// 8-bit compare timer with 4-bit prescaler and sticky MATCH flag.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   i_cnt_we/i_cmp_we/i_ctrl_we : write strobes for TMR_CNT/TMR_CMP/TMR_CTRL
//   i_w1c              : STATUS write with bit0 set (clear MATCH)
//   i_wdata            : bus write data
//   o_cnt/o_cmp/o_ctrl : current register values
//   o_match            : MATCH flag
//   o_match_next       : value MATCH takes at the coming edge (for write-first readback)
module bus_timer
    import cpu_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_cnt_we,
    input  logic       i_cmp_we,
    input  logic       i_ctrl_we,
    input  logic       i_w1c,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_cnt,
    output logic [7:0] o_cmp,
    output logic [7:0] o_ctrl,
    output logic       o_match,
    output logic       o_match_next
);

    logic [3:0] r_presc;
    logic [7:0] r_cnt;
    logic [7:0] r_cmp;
    logic [7:0] r_ctrl;
    logic       r_match;

    logic       w_en;
    logic [3:0] w_presc_lim;
    logic       w_tick;
    logic       w_hit;
    logic [3:0] w_presc_d;
    logic [7:0] w_cnt_d;
    logic       w_match_d;

    assign w_en        = r_ctrl[CTRL_EN];
    assign w_presc_lim = r_ctrl[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
    // Tick decisions use the registered EN, so a write clearing EN on a
    // tick edge still lets that tick apply.
    assign w_tick      = w_en && (r_presc == w_presc_lim);
    assign w_hit       = w_tick && (r_cnt == r_cmp);

    always_comb begin
        w_presc_d = r_presc;
        if (!w_en || w_tick) begin
            w_presc_d = 4'd0;
        end else begin
            w_presc_d = r_presc + 4'd1;
        end
    end

    always_comb begin
        w_cnt_d = r_cnt;
        // A CPU write overrides the tick; the prescaler is unaffected.
        if (i_cnt_we) begin
            w_cnt_d = i_wdata;
        end else if (w_hit) begin
            w_cnt_d = 8'd0;
        end else if (w_tick) begin
            w_cnt_d = r_cnt + 8'd1;
        end
    end

    always_comb begin
        w_match_d = r_match;
        // Setting wins over a simultaneous clear.
        if (w_hit) begin
            w_match_d = 1'b1;
        end else if (i_w1c) begin
            w_match_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= 4'd0;
            r_cnt   <= 8'd0;
            r_cmp   <= TMR_CMP_RST;
            r_ctrl  <= 8'd0;
            r_match <= 1'b0;
        end else begin
            r_presc <= w_presc_d;
            r_cnt   <= w_cnt_d;
            r_match <= w_match_d;
            if (i_cmp_we) begin
                r_cmp <= i_wdata;
            end
            if (i_ctrl_we) begin
                r_ctrl <= ctrl_mask(i_wdata);
            end
        end
    end

    assign o_cnt        = r_cnt;
    assign o_cmp        = r_cmp;
    assign o_ctrl       = r_ctrl;
    assign o_match      = r_match;
    assign o_match_next = w_match_d;

endmodule

// File: rtl/cpu_bus_target.sv
// cpu_bus_target
// CPU byte-bus target: scratch RAM at 0x00, GPIO and compare timer in the
// MMIO window at 0x70. Every cycle is a read with one cycle latency.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   address    : 7-bit byte address
//   write      : write strobe for data_in at address
//   data_in    : write data
//   data_out   : registered read data
//   gpio_in    : asynchronous inputs (synchronized internally)
//   gpio_out   : GPIO output register
//   irq        : timer interrupt (MATCH & IE)
module cpu_bus_target
    import cpu_bus_pkg::*;
#(
    parameter int unsigned RAM_DEPTH   = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] address,
    input  logic       write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic       irq
);

    localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic [7:0]        r_ram [RAM_DEPTH];
    logic [7:0]        r_sync [SYNC_STAGES];
    logic [7:0]        r_gpio_out;
    logic [7:0]        r_data_out;

    logic              w_ram_sel;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [7:0]        w_gpio_sync;
    logic [7:0]        w_rd_data;
    logic [7:0]        w_dout_d;
    logic [7:0]        w_tmr_cnt;
    logic [7:0]        w_tmr_cmp;
    logic [7:0]        w_tmr_ctrl;
    logic              w_match;
    logic              w_match_next;
    logic              w_wr_gpio;
    logic              w_wr_cnt;
    logic              w_wr_cmp;
    logic              w_wr_ctrl;
    logic              w_w1c;

    assign w_ram_sel   = ({25'd0, address} < RAM_DEPTH);
    assign w_ram_idx   = address[RAM_AW-1:0];
    assign w_gpio_sync = r_sync[SYNC_STAGES-1];

    assign w_wr_gpio = write && (address == ADDR_GPIO_OUT);
    assign w_wr_cnt  = write && (address == ADDR_TMR_CNT);
    assign w_wr_cmp  = write && (address == ADDR_TMR_CMP);
    assign w_wr_ctrl = write && (address == ADDR_TMR_CTRL);
    assign w_w1c     = write && (address == ADDR_STATUS) && data_in[0];

    bus_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_cnt_we     (w_wr_cnt),
        .i_cmp_we     (w_wr_cmp),
        .i_ctrl_we    (w_wr_ctrl),
        .i_w1c        (w_w1c),
        .i_wdata      (data_in),
        .o_cnt        (w_tmr_cnt),
        .o_cmp        (w_tmr_cmp),
        .o_ctrl       (w_tmr_ctrl),
        .o_match      (w_match),
        .o_match_next (w_match_next)
    );

    // Current contents of the addressed location.
    always_comb begin
        w_rd_data = 8'h00;
        if (w_ram_sel) begin
            w_rd_data = r_ram[w_ram_idx];
        end else begin
            case (address)
                ADDR_GPIO_OUT: w_rd_data = r_gpio_out;
                ADDR_GPIO_IN:  w_rd_data = w_gpio_sync;
                ADDR_TMR_CNT:  w_rd_data = w_tmr_cnt;
                ADDR_TMR_CMP:  w_rd_data = w_tmr_cmp;
                ADDR_TMR_CTRL: w_rd_data = w_tmr_ctrl;
                ADDR_STATUS:   w_rd_data = {7'd0, w_match};
                default:       w_rd_data = 8'h00;
            endcase
        end
    end

    // Write-first readback: writable locations echo data_in, STATUS shows
    // its post-update value, read-only/unmapped keep their normal value.
    always_comb begin
        w_dout_d = w_rd_data;
        if (write) begin
            if (w_ram_sel) begin
                w_dout_d = data_in;
            end else begin
                case (address)
                    ADDR_GPIO_OUT,
                    ADDR_TMR_CNT,
                    ADDR_TMR_CMP,
                    ADDR_TMR_CTRL: w_dout_d = data_in;
                    ADDR_STATUS:   w_dout_d = {7'd0, w_match_next};
                    default:       w_dout_d = w_rd_data;
                endcase
            end
        end
    end

    // RAM has no reset; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset && write && w_ram_sel) begin
            r_ram[w_ram_idx] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= 8'h00;
            r_gpio_out <= 8'h00;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 8'h00;
            end
        end else begin
            r_data_out <= w_dout_d;
            if (w_wr_gpio) begin
                r_gpio_out <= data_in;
            end
            r_sync[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign data_out = r_data_out;
    assign gpio_out = r_gpio_out;
    // Both operands are flops, so irq has no combinational path from the bus.
    assign irq      = w_match & w_tmr_ctrl[CTRL_IE];

endmodule

// File: tb/tb_cpu_bus_target.sv
// tb_cpu_bus_target
// Directed bench for cpu_bus_target with a cycle-level behavioural model of
// the memory map and timer, checked every cycle, plus literal expectations.
module tb_cpu_bus_target;

    localparam int RAM_DEPTH   = 64;
    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] address;
    logic       write;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic       irq;

    always #5 clk = ~clk;

    cpu_bus_target #(
        .RAM_DEPTH   (RAM_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .write    (write),
        .data_in  (data_in),
        .data_out (data_out),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_ram [RAM_DEPTH];
    bit m_ram_ok [RAM_DEPTH];
    int m_sync [SYNC_STAGES];
    int m_gpio, m_cnt, m_cmp, m_ctrl, m_presc, m_dout;
    bit m_match, m_dout_ok, m_live;

    always @(posedge clk) begin : model
        int a, rd, limit, nxt_match;
        bit tick, hit, rd_ok, en;
        a = int'(address);
        if (reset) begin
            m_gpio    <= 0;
            m_cnt     <= 0;
            m_cmp     <= 255;
            m_ctrl    <= 0;
            m_presc   <= 0;
            m_match   <= 1'b0;
            m_dout    <= 0;
            m_dout_ok <= 1'b1;
            m_live    <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] <= 0;
        end else if (m_live) begin
            en    = (m_ctrl % 2) == 1;
            limit = m_ctrl / 16;
            tick  = en && (m_presc == limit);
            hit   = tick && (m_cnt == m_cmp);
            rd    = 0;
            rd_ok = 1'b1;
            if (a < RAM_DEPTH) begin
                rd    = m_ram[a];
                rd_ok = m_ram_ok[a];
            end else begin
                case (a)
                    'h70: rd = m_gpio;
                    'h71: rd = m_sync[SYNC_STAGES-1];
                    'h72: rd = m_cnt;
                    'h73: rd = m_cmp;
                    'h74: rd = m_ctrl;
                    'h75: rd = int'(m_match);
                    default: rd = 0;
                endcase
            end
            if (hit) nxt_match = 1;
            else if (write && a == 'h75 && data_in[0]) nxt_match = 0;
            else nxt_match = int'(m_match);

            if (write && (a < RAM_DEPTH || a inside {'h70, 'h72, 'h73, 'h74})) begin
                m_dout    <= int'(data_in);
                m_dout_ok <= 1'b1;
            end else if (write && a == 'h75) begin
                m_dout    <= nxt_match;
                m_dout_ok <= 1'b1;
            end else begin
                m_dout    <= rd;
                m_dout_ok <= rd_ok;
            end

            m_match <= (nxt_match != 0);
            m_presc <= (!en || tick) ? 0 : m_presc + 1;
            if (write && a == 'h72) m_cnt <= int'(data_in);
            else if (hit) m_cnt <= 0;
            else if (tick) m_cnt <= (m_cnt + 1) % 256;
            if (write && a == 'h73) m_cmp <= int'(data_in);
            if (write && a == 'h74) m_ctrl <= int'(data_in) & 'hF3;
            if (write && a == 'h70) m_gpio <= int'(data_in);
            if (write && a < RAM_DEPTH) begin
                m_ram[a]    <= int'(data_in);
                m_ram_ok[a] <= 1'b1;
            end
            m_sync[0] <= int'(gpio_in);
            for (int i = 1; i < SYNC_STAGES; i++) m_sync[i] <= m_sync[i-1];
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            if (m_dout_ok) chk("model data_out", int'(data_out), m_dout);
            chk("model gpio_out", int'(gpio_out), m_gpio);
            chk("model irq", int'(irq), int'(m_match && ((m_ctrl / 2) % 2 == 1)));
        end
    end

    // One bus cycle: drive at negedge, return at the following negedge.
    task automatic cyc(input bit rst, input bit wr, input logic [6:0] a, input logic [7:0] d);
        reset   = rst;
        write   = wr;
        address = a;
        data_in = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [6:0] a);
        cyc(1'b0, 1'b0, a, 8'h00);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b1, a, d);
    endtask

    int exp_cnt [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int found;

    initial begin
        reset   = 1'b1;
        write   = 1'b0;
        address = 7'h00;
        data_in = 8'h00;
        gpio_in = 8'h00;
        @(negedge clk);
        cyc(1'b1, 1'b0, 7'h00, 8'h00);
        cyc(1'b1, 1'b0, 7'h00, 8'h00);
        chk("reset data_out", int'(data_out), 'h00);
        chk("reset gpio_out", int'(gpio_out), 'h00);
        chk("reset irq", int'(irq), 0);

        // RAM
        wr(7'h00, 8'hA5);
        wr(7'h3F, 8'h3C);
        rd(7'h00); chk("ram 0x00", int'(data_out), 'hA5);
        rd(7'h3F); chk("ram 0x3F", int'(data_out), 'h3C);
        rd(7'h50); chk("unmapped 0x50", int'(data_out), 'h00);

        // Write-first
        wr(7'h10, 8'h77); chk("write-first 0x10", int'(data_out), 'h77);

        // GPIO out, then reset during a write to GPIO_OUT
        wr(7'h70, 8'h5A); chk("gpio_out write", int'(gpio_out), 'h5A);
        cyc(1'b1, 1'b1, 7'h70, 8'h33); chk("gpio_out reset wins", int'(gpio_out), 'h00);

        // GPIO input synchronizer latency
        found   = 0;
        gpio_in = 8'hC3;
        for (int k = 1; k <= 10; k++) begin
            rd(7'h71);
            if (found == 0 && data_out == 8'hC3) found = k;
        end
        chk("gpio_in latency", found, SYNC_STAGES + 1);

        // Timer: CMP=3, PRESC=1, EN+IE
        wr(7'h73, 8'h03);
        wr(7'h72, 8'h00);
        wr(7'h74, 8'h13);
        for (int i = 0; i < 9; i++) begin
            rd(7'h72);
            chk($sformatf("tmr_cnt[%0d]", i), int'(data_out), exp_cnt[i]);
            if (i == 6) chk("irq before wrap", int'(irq), 0);
            if (i == 7) chk("irq at wrap", int'(irq), 1);
        end
        wr(7'h75, 8'h01);
        chk("status w1c readback", int'(data_out), 'h00);
        chk("irq after w1c", int'(irq), 0);

        // W1C on the same edge as a match tick
        wr(7'h74, 8'h00);
        wr(7'h72, 8'h05);
        wr(7'h73, 8'h05);
        wr(7'h74, 8'h03);
        wr(7'h75, 8'h01);
        chk("match set beats w1c", int'(data_out), 'h01);
        chk("irq set beats w1c", int'(irq), 1);

        // CNT write on a tick edge (PRESC=0 ticks every cycle)
        wr(7'h72, 8'h80); chk("cnt write-first", int'(data_out), 'h80);
        rd(7'h72);        chk("cnt write beats tick", int'(data_out), 'h80);

        // CTRL unimplemented bits, reserved space
        wr(7'h74, 8'hFC);
        rd(7'h74);        chk("ctrl bits 3:2", int'(data_out), 'hF0);
        wr(7'h76, 8'hAB); chk("reserved write readback", int'(data_out), 'h00);
        rd(7'h76);        chk("reserved read", int'(data_out), 'h00);
        wr(7'h70, 8'hEE);

        // Mid-operation reset
        cyc(1'b1, 1'b0, 7'h00, 8'h00);
        chk("reset2 data_out", int'(data_out), 'h00);
        chk("reset2 gpio_out", int'(gpio_out), 'h00);
        chk("reset2 irq", int'(irq), 0);
        rd(7'h72); chk("reset2 cnt", int'(data_out), 'h00);
        rd(7'h73); chk("reset2 cmp", int'(data_out), 'hFF);
        rd(7'h74); chk("reset2 ctrl", int'(data_out), 'h00);
        rd(7'h75); chk("reset2 status", int'(data_out), 'h00);
        rd(7'h00); chk("ram kept 0x00", int'(data_out), 'hA5);
        rd(7'h10); chk("ram kept 0x10", int'(data_out), 'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
